md_unit: RTL and testbench

Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits in the Execute stage beside the ALU and executes mult, multu, div, divu, mthi and mtlo, with a configurable operand width and configurable per-operation latency. It drives a busy flag that the hazard unit uses to stall mfhi, mflo and any further MD instructions until the result commits.

---
 rtl/md_unit_pkg.sv | 26 ++
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: mdop codes, FSM states,
// and the helper that tells HI/LO-producing ops from register moves.
package md_unit_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } md_state_e;

   // mult, multu, div and divu occupy codes 0..3.
   function automatic logic is_md_op(input logic [2:0] op);
      return ~op[2];
   endfunction

   function automatic logic is_mult_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. The result is computed on the
// start edge and held in phi/plo; a down-counter models the latency.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mdop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   // Handshake: start qualifies mdop/a/b for one cycle; the hazard unit must
   // hold off further MD starts while busy is high, and any start seen in RUN
   // is dropped. busy covers the accepting cycle so a following mfhi stalls.

   md_state_e        state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] phi, phi_nxt, plo, plo_nxt;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;

   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic [WIDTH-1:0]   mag_a, mag_b, div_s, div_u;
   logic [WIDTH-1:0]   q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;
   logic               b_zero;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic [CW-1:0]      lat_sel;

   always_comb begin
      prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

      b_zero = (b == '0);
      mag_a  = a[WIDTH-1] ? -a : a;
      mag_b  = b[WIDTH-1] ? -b : b;
      // Divisor forced to 1 on zero so the datapath never produces X; the
      // result is discarded in that case anyway.
      div_s  = b_zero ? WIDTH'(1) : mag_b;
      div_u  = b_zero ? WIDTH'(1) : b;

      // -2^(W-1) / -1 falls out of the magnitude path: the quotient magnitude
      // 2^(W-1) negates to itself and the remainder is 0.
      q_mag = mag_a / div_s;
      r_mag = mag_a % div_s;
      quo_s = (a[WIDTH-1] ^ b[WIDTH-1]) ? -q_mag : q_mag;
      rem_s = a[WIDTH-1] ? -r_mag : r_mag;
      quo_u = a / div_u;
      rem_u = a % div_u;

      res_hi = hi;
      res_lo = lo;
      case (mdop)
         MD_MULT:  {res_hi, res_lo} = prod_s;
         MD_MULTU: {res_hi, res_lo} = prod_u;
         MD_DIV:   if (!b_zero) begin
                      res_hi = rem_s;
                      res_lo = quo_s;
                   end
         MD_DIVU:  if (!b_zero) begin
                      res_hi = rem_u;
                      res_lo = quo_u;
                   end
         default: ;
      endcase

      lat_sel = is_mult_op(mdop) ? CW'(MULT_LAT) : CW'(DIV_LAT);
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      phi_nxt   = phi;
      plo_nxt   = plo;
      hi_nxt    = hi;
      lo_nxt    = lo;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (is_md_op(mdop)) begin
                  phi_nxt   = res_hi;
                  plo_nxt   = res_lo;
                  cnt_nxt   = lat_sel;
                  state_nxt = S_RUN;
               end else if (mdop == MD_MTHI) begin
                  hi_nxt = a;
               end else if (mdop == MD_MTLO) begin
                  lo_nxt = a;
               end
            end
         end
         S_RUN: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               hi_nxt    = phi;
               lo_nxt    = plo;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_RUN) || (start && is_md_op(mdop) && (state == S_IDLE));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         phi   <= '0;
         plo   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         phi   <= phi_nxt;
         plo   <= plo_nxt;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Randomized bench for md_unit: a 32-bit and a 16-bit/min-latency instance,
// a plain-arithmetic HI/LO model, and a commit monitor fed by an expected queue.
module tb_md_unit;
   import md_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start0, start1;
   logic [2:0]  mdop0, mdop1;
   logic [31:0] a0, b0, hi0, lo0;
   logic [15:0] a1, b1, hi1, lo1;
   logic        busy0, busy1;

   md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) u32 (
      .clk(clk), .reset(reset), .start(start0), .mdop(mdop0), .a(a0), .b(b0),
      .busy(busy0), .hi(hi0), .lo(lo0));

   md_unit #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(3)) u16 (
      .clk(clk), .reset(reset), .start(start1), .mdop(mdop1), .a(a1), .b(b1),
      .busy(busy1), .hi(hi1), .lo(lo1));

   int checks = 0;
   int failures = 0;
   logic [31:0] m_hi[2];
   logic [31:0] m_lo[2];
   // entry = {dut[7:0], lat[7:0], hi[31:0], lo[31:0]}
   logic [79:0] exp_q[$];
   bit abandon = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int wid(input int d);
      return (d != 0) ? 16 : 32;
   endfunction

   function automatic int lat_of(input int d, input logic [2:0] op);
      if (op < 3'd2) return (d != 0) ? 1 : 5;
      return (d != 0) ? 3 : 10;
   endfunction

   function automatic logic [31:0] hi_of(input int d);
      return (d != 0) ? {16'b0, hi1} : hi0;
   endfunction

   function automatic logic [31:0] lo_of(input int d);
      return (d != 0) ? {16'b0, lo1} : lo0;
   endfunction

   function automatic logic busy_of(input int d);
      return (d != 0) ? busy1 : busy0;
   endfunction

   function automatic logic mdstart_of(input int d);
      return (d != 0) ? (start1 && mdop1 < 3'd4) : (start0 && mdop0 < 3'd4);
   endfunction

   function automatic longint sext(input logic [31:0] v, input int w);
      longint t;
      t = longint'({32'b0, v});
      t = t <<< (64 - w);
      return t >>> (64 - w);
   endfunction

   // Reference: HI/LO after one op, from whole-number arithmetic on w-bit values.
   task automatic ref_md(input int w, input logic [2:0] op, input logic [31:0] a, b,
                         input logic [31:0] oh, ol, output logic [31:0] h, l);
      longint sa, sb, p, q, r, mask;
      longint unsigned ua, ub, pu;
      mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
      sa = sext(a, w);
      sb = sext(b, w);
      ua = {32'b0, a} & mask;
      ub = {32'b0, b} & mask;
      h = oh;
      l = ol;
      case (op)
         MD_MULT:  begin p = sa * sb; h = 32'((p >>> w) & mask); l = 32'(p & mask); end
         MD_MULTU: begin pu = ua * ub; h = 32'((pu >> w) & mask); l = 32'(pu & mask); end
         MD_DIV:   if (ub != 0) begin
                      q = sa / sb; r = sa % sb;
                      l = 32'(q & mask); h = 32'(r & mask);
                   end
         MD_DIVU:  if (ub != 0) begin l = 32'(ua / ub); h = 32'(ua % ub); end
         MD_MTHI:  h = 32'(ua);
         MD_MTLO:  l = 32'(ua);
         default: ;
      endcase
   endtask

   task automatic drive(input int d, input logic s, input logic [2:0] op, input logic [31:0] a, b);
      if (d != 0) begin
         start1 = s; mdop1 = op; a1 = a[15:0]; b1 = b[15:0];
      end else begin
         start0 = s; mdop0 = op; a0 = a; b0 = b;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called #1 after a rising edge; returns #1 after the edge following the
   // operation's last effect, so the next call can start back-to-back.
   task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a, b, input bit poke);
      logic [31:0] nh, nl;
      int lat;
      ref_md(wid(d), op, a, b, m_hi[d], m_lo[d], nh, nl);
      drive(d, 1'b1, op, a, b);
      lat = lat_of(d, op);
      if (op < 3'd4) exp_q.push_back({8'(d), 8'(lat), nh, nl});
      @(posedge clk);
      #1;
      drive(d, 1'b0, 3'd7, 32'h0, 32'h0);
      if (op < 3'd4) begin
         for (int k = 0; k < lat; k++) begin
            if (poke && k == 1) drive(d, 1'b1, MD_MTHI, 32'd5, 32'd0);
            @(posedge clk);
            #1;
            if (poke && k == 1) begin
               drive(d, 1'b0, 3'd7, 32'h0, 32'h0);
               chk("ignored_start_hi", hi_of(d), m_hi[d]);
            end
         end
      end else begin
         chk("move_hi", hi_of(d), nh);
         chk("move_lo", lo_of(d), nl);
      end
      m_hi[d] = nh;
      m_lo[d] = nl;
   endtask

   // Commit monitor: counts busy cycles of the op at the queue head and,
   // in the cycle after the expected commit, compares HI/LO and busy.
   int bcnt = 0;
   always @(negedge clk) begin
      logic [79:0] h;
      int d, lat;
      if (reset || abandon) begin
         bcnt = 0;
      end else if (bcnt == 0) begin
         if (exp_q.size() == 0) begin
            if (busy0 || busy1) chk("spurious_busy", {30'b0, busy1, busy0}, 32'd0);
         end else begin
            h = exp_q[0];
            d = int'(h[79:72]);
            if (busy_of(d)) bcnt = 1;
         end
      end else begin
         h = exp_q[0];
         d = int'(h[79:72]);
         lat = int'(h[71:64]);
         if (bcnt == lat + 1) begin
            chk("commit_hi", hi_of(d), h[63:32]);
            chk("commit_lo", lo_of(d), h[31:0]);
            chk("busy_after_commit", {31'b0, busy_of(d)}, {31'b0, mdstart_of(d)});
            void'(exp_q.pop_front());
            bcnt = 0;
            if (exp_q.size() > 0) begin
               h = exp_q[0];
               if (busy_of(int'(h[79:72]))) bcnt = 1;
            end
         end else if (!busy_of(d)) begin
            chk("busy_cycles", bcnt, lat + 1);
            void'(exp_q.pop_front());
            bcnt = 0;
         end else begin
            bcnt++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ra, rb, mask, minv;
      logic [2:0]  op;
      int d, sel;
      m_hi = '{32'h0, 32'h0};
      m_lo = '{32'h0, 32'h0};
      reset = 1'b1;
      drive(0, 1'b0, 3'd7, 32'h0, 32'h0);
      drive(1, 1'b0, 3'd7, 32'h0, 32'h0);
      idle(3);
      chk("reset_hi32", hi0, 32'h0);
      chk("reset_lo32", lo0, 32'h0);
      chk("reset_busy32", {31'b0, busy0}, 32'h0);
      chk("reset_hi16", {16'b0, hi1}, 32'h0);
      chk("reset_busy16", {31'b0, busy1}, 32'h0);
      reset = 1'b0;
      idle(1);

      issue(0, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      chk("tp_mult_hi", hi0, 32'hFFFF_FFFF);
      chk("tp_mult_lo", lo0, 32'hFFFF_FFFA);
      issue(0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      chk("tp_multu_hi", hi0, 32'hFFFF_FFFE);
      chk("tp_multu_lo", lo0, 32'h0000_0001);
      issue(0, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("tp_div_lo", lo0, 32'hFFFF_FFFD);
      chk("tp_div_hi", hi0, 32'hFFFF_FFFF);
      issue(0, MD_DIVU, 32'd7, 32'd2, 1'b0);
      chk("tp_divu_lo", lo0, 32'd3);
      chk("tp_divu_hi", hi0, 32'd1);
      issue(0, MD_MTLO, 32'h1234, 32'd0, 1'b0);
      issue(0, MD_DIV, 32'd55, 32'd0, 1'b0);
      chk("tp_div0_lo", lo0, 32'h1234);
      issue(0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("tp_ovf_lo", lo0, 32'h8000_0000);
      chk("tp_ovf_hi", hi0, 32'h0);
      issue(1, MD_MULT, 32'h0100, 32'h0100, 1'b0);
      chk("tp_lat1_hi", {16'b0, hi1}, 32'h0001);
      chk("tp_lat1_lo", {16'b0, lo1}, 32'h0000);
      idle(2);

      // Reset two edges into a 5-cycle mult: nothing may commit afterwards.
      issue(0, MD_MTHI, 32'hAAAA_5555, 32'd0, 1'b0);
      abandon = 1'b1;
      drive(0, 1'b1, MD_MULT, 32'd3, 32'd4);
      idle(1);
      drive(0, 1'b0, 3'd7, 32'h0, 32'h0);
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      abandon = 1'b0;
      m_hi = '{32'h0, 32'h0};
      m_lo = '{32'h0, 32'h0};
      chk("rst_run_hi", hi0, 32'h0);
      chk("rst_run_lo", lo0, 32'h0);
      chk("rst_run_busy", {31'b0, busy0}, 32'h0);
      idle(8);
      chk("rst_nocommit_hi", hi0, 32'h0);
      chk("rst_nocommit_lo", lo0, 32'h0);

      for (int i = 0; i < 80; i++) begin
         d = ($urandom_range(0, 3) == 0) ? 1 : 0;
         mask = (d != 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
         minv = (d != 0) ? 32'h0000_8000 : 32'h8000_0000;
         op = 3'($urandom_range(0, 7));
         ra = $urandom & mask;
         rb = $urandom & mask;
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 32'h0;
         else if (sel == 1) begin ra = minv; rb = mask; end
         else if (sel == 2) rb = 32'($urandom_range(1, 5));
         else if (sel == 3) rb = (-32'($urandom_range(1, 5))) & mask;
         issue(d, op, ra, rb, 1'b0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      idle(4);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
